// File: rtl/fm_dsp_pkg.sv
// Shared FM DSP definitions: datapath widths, scheduler state encoding and a
// constant-evaluable clog2 used to size tags and counters.
package fm_dsp_pkg;

  localparam int unsigned DvdW = 36;
  localparam int unsigned DvsW = 24;
  localparam int unsigned QuoW = 36;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StGap
  } sched_st_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_share_sched_if.sv
// Channel request, divider and result bus of the divider-sharing scheduler.
// The master modport is the scheduler; the slave modport is its environment.
interface div_share_sched_if
  import fm_dsp_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned DVD_W = DvdW,
  parameter int unsigned DVS_W = DvsW,
  parameter int unsigned QUO_W = QuoW
);
  logic [N_REQ-1:0]       REQ_RDY;
  logic [N_REQ-1:0]       REQ_ACK;
  logic [N_REQ*DVD_W-1:0] REQ_DIVIDEND;
  logic [N_REQ*DVS_W-1:0] REQ_DIVISOR;
  logic                   DIV_ND;
  logic [DVD_W-1:0]       DIV_DIVIDEND;
  logic [DVS_W-1:0]       DIV_DIVISOR;
  logic                   DIV_RDY;
  logic [QUO_W-1:0]       DIV_QUOTIENT;
  logic [N_REQ-1:0]       OUT_VALID;
  logic [QUO_W-1:0]       OUT_QUOTIENT;
  logic                   ERR_UNDERFLOW;

  modport master (
    input  REQ_RDY, REQ_DIVIDEND, REQ_DIVISOR, DIV_RDY, DIV_QUOTIENT,
    output REQ_ACK, DIV_ND, DIV_DIVIDEND, DIV_DIVISOR, OUT_VALID, OUT_QUOTIENT, ERR_UNDERFLOW
  );

  modport slave (
    output REQ_RDY, REQ_DIVIDEND, REQ_DIVISOR, DIV_RDY, DIV_QUOTIENT,
    input  REQ_ACK, DIV_ND, DIV_DIVIDEND, DIV_DIVISOR, OUT_VALID, OUT_QUOTIENT, ERR_UNDERFLOW
  );

endinterface

// File: rtl/tag_fifo.sv
// Synchronous FIFO of owner tags for divisions in flight.
// Push when full and pop when empty are ignored.
module tag_fifo
  import fm_dsp_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [Width-1:0] din_i,
  output logic [Width-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? clog2(Depth) : 1;
  localparam int unsigned CntW = clog2(Depth) + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rd_q];

  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = (wr_q == PtrW'(Depth - 1)) ? '0 : wr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == PtrW'(Depth - 1)) ? '0 : rd_q + PtrW'(1);
    end
    cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/div_share_sched.sv
// Round-robin scheduler sharing one pipelined divider between N_REQ channels.
// Each issue is tagged in a FIFO so returned quotients are routed to their owner.
module div_share_sched
  import fm_dsp_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned DVD_W      = DvdW,
  parameter int unsigned DVS_W      = DvsW,
  parameter int unsigned QUO_W      = QuoW,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ISSUE_GAP  = 1
) (
  input logic               CLK,
  input logic               CLK_RDY,
  div_share_sched_if.master bus
);
  localparam int unsigned TagW = (N_REQ > 1) ? clog2(N_REQ) : 1;
  localparam int unsigned GapW = clog2(ISSUE_GAP + 1);

  sched_st_e        state_q, state_d;
  logic [TagW-1:0]  ptr_q, ptr_d, grant_q, grant_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [N_REQ-1:0] ack_q, ack_d, out_valid_q, out_valid_d;
  logic             nd_q, nd_d, err_q, err_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [QUO_W-1:0] out_quo_q, out_quo_d;

  logic             pick_found;
  logic [TagW-1:0]  pick_idx, cand;
  logic [DVD_W-1:0] pick_dvd;
  logic [DVS_W-1:0] pick_dvs;
  logic             push, pop, fifo_full, fifo_empty;
  logic [TagW-1:0]  fifo_dout;

  // First requester strictly after the last grant, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = TagW'((32'(ptr_q) + k) % N_REQ);
      if (!pick_found && bus.REQ_RDY[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_dvd = bus.REQ_DIVIDEND[32'(pick_idx) * DVD_W +: DVD_W];
    pick_dvs = bus.REQ_DIVISOR[32'(pick_idx) * DVS_W +: DVS_W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    ack_d   = '0;
    nd_d    = 1'b0;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    push    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // fifo_full comes from the registered count, so a same-cycle pop does not unblock.
        if (pick_found && !fifo_full) begin
          grant_d        = pick_idx;
          ack_d[pick_idx] = 1'b1;
          nd_d           = 1'b1;
          dvd_d          = pick_dvd;
          dvs_d          = (pick_dvs == '0) ? DVS_W'(1) : pick_dvs;
          state_d        = StIssue;
        end
      end
      StIssue: begin
        push    = 1'b1;
        ptr_d   = grant_q;
        gap_d   = GapW'(ISSUE_GAP);
        state_d = StGap;
      end
      StGap: begin
        if (gap_q <= GapW'(1)) state_d = StIdle;
        else                   gap_d   = gap_q - GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_valid_d = '0;
    out_quo_d   = out_quo_q;
    err_d       = err_q;
    pop         = 1'b0;
    if (bus.DIV_RDY) begin
      if (fifo_empty) begin
        err_d = 1'b1;
      end else begin
        pop                    = 1'b1;
        out_valid_d[fifo_dout] = 1'b1;
        out_quo_d              = bus.DIV_QUOTIENT;
      end
    end
  end

  always_ff @(posedge CLK or negedge CLK_RDY) begin
    if (!CLK_RDY) begin
      state_q     <= StIdle;
      ptr_q       <= TagW'(N_REQ - 1);
      grant_q     <= '0;
      gap_q       <= '0;
      ack_q       <= '0;
      nd_q        <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      out_valid_q <= '0;
      out_quo_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      gap_q       <= gap_d;
      ack_q       <= ack_d;
      nd_q        <= nd_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      err_q       <= err_d;
    end
  end

  tag_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(TagW)
  ) u_tag_fifo (
    .clk_i  (CLK),
    .rst_ni (CLK_RDY),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (grant_q),
    .dout_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign bus.REQ_ACK       = ack_q;
  assign bus.DIV_ND        = nd_q;
  assign bus.DIV_DIVIDEND  = dvd_q;
  assign bus.DIV_DIVISOR   = dvs_q;
  assign bus.OUT_VALID     = out_valid_q;
  assign bus.OUT_QUOTIENT  = out_quo_q;
  assign bus.ERR_UNDERFLOW = err_q;

endmodule
